// File: rtl/load_unit.sv
// load_unit: RISC-V load reader; fetches one or two aligned words and returns the extended result.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module load_unit #(
  parameter int unsigned ALLOW_MISALIGNED = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ld_valid,
  output logic        o_ld_ready,
  input  logic [31:0] i_ld_addr,
  input  logic [2:0]  i_ld_funct3,
  output logic        o_ld_done,
  output logic [31:0] o_ld_data,
  output logic        o_ld_err,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  offset, offset_nx;
  logic [2:0]  funct3, funct3_nx;
  logic [31:0] word0, word0_nx;
  logic        mem_req_nx;
  logic [31:0] mem_addr_nx;
  logic        done_nx;
  logic [31:0] data_nx;
  logic        err_nx;
  logic        legal;
  logic        misaligned;

  // Only LH/LHU (size code 01) and LW (10) can span two words.
  function automatic logic crosses(input logic [1:0] off, input logic [1:0] size_code);
    return ((size_code == 2'b01) && (off == 2'b11)) ||
           ((size_code == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [31:0] sh;
    sh = 32'(pair >> {off, 3'b000});
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign o_ld_ready = (state == IDLE) && i_reset_n;

  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    case (i_ld_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
    if ((i_ld_funct3[1:0] == 2'b01) && i_ld_addr[0])
      misaligned = 1'b1;
    if ((i_ld_funct3 == 3'b010) && (i_ld_addr[1:0] != 2'b00))
      misaligned = 1'b1;
  end

  always_comb begin
    state_nx    = state;
    offset_nx   = offset;
    funct3_nx   = funct3;
    word0_nx    = word0;
    mem_req_nx  = o_mem_req;
    mem_addr_nx = o_mem_addr;
    done_nx     = 1'b0;
    data_nx     = o_ld_data;
    err_nx      = o_ld_err;

    case (state)
      IDLE: begin
        if (i_ld_valid) begin
          offset_nx = i_ld_addr[1:0];
          funct3_nx = i_ld_funct3;
          if (!legal || (misaligned && (ALLOW_MISALIGNED == 0))) begin
            state_nx = RESP;
            done_nx  = 1'b1;
            data_nx  = 32'd0;
            err_nx   = 1'b1;
          end else begin
            state_nx    = RD_LO;
            mem_req_nx  = 1'b1;
            mem_addr_nx = {i_ld_addr[31:2], 2'b00};
          end
        end
      end
      RD_LO: begin
        if (i_mem_ack) begin
          word0_nx = i_mem_rdata;
          if (crosses(offset, funct3[1:0])) begin
            state_nx    = RD_HI;
            mem_addr_nx = o_mem_addr + 32'd4;
          end else begin
            state_nx   = RESP;
            mem_req_nx = 1'b0;
            done_nx    = 1'b1;
            err_nx     = 1'b0;
            data_nx    = extract({32'd0, i_mem_rdata}, offset, funct3);
          end
        end
      end
      RD_HI: begin
        if (i_mem_ack) begin
          state_nx   = RESP;
          mem_req_nx = 1'b0;
          done_nx    = 1'b1;
          err_nx     = 1'b0;
          data_nx    = extract({i_mem_rdata, word0}, offset, funct3);
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      offset     <= 2'd0;
      funct3     <= 3'd0;
      word0      <= 32'd0;
      o_mem_req  <= 1'b0;
      o_mem_addr <= 32'd0;
      o_ld_done  <= 1'b0;
      o_ld_data  <= 32'd0;
      o_ld_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      offset     <= offset_nx;
      funct3     <= funct3_nx;
      word0      <= word0_nx;
      o_mem_req  <= mem_req_nx;
      o_mem_addr <= mem_addr_nx;
      o_ld_done  <= done_nx;
      o_ld_data  <= data_nx;
      o_ld_err   <= err_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_unit.sv
// tb_load_unit: randomized scoreboard bench for load_unit with a byte-level reference model.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_load_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid, ld_ready, ld_done, ld_err, mem_req, mem_ack;
  logic [31:0] ld_addr, ld_data, mem_addr, mem_rdata;
  logic [2:0]  ld_funct3;

  logic        na_valid, na_ready, na_done, na_err, na_req, na_ack;
  logic [31:0] na_addr, na_data, na_maddr, na_rdata;
  logic [2:0]  na_funct3;

  always #5 clk = ~clk;

  load_unit #(.ALLOW_MISALIGNED(1)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_ld_valid(ld_valid), .o_ld_ready(ld_ready),
    .i_ld_addr(ld_addr), .i_ld_funct3(ld_funct3),
    .o_ld_done(ld_done), .o_ld_data(ld_data), .o_ld_err(ld_err),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  load_unit #(.ALLOW_MISALIGNED(0)) dut_na (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_ld_valid(na_valid), .o_ld_ready(na_ready),
    .i_ld_addr(na_addr), .i_ld_funct3(na_funct3),
    .o_ld_done(na_done), .o_ld_data(na_data), .o_ld_err(na_err),
    .o_mem_req(na_req), .o_mem_addr(na_maddr),
    .i_mem_ack(na_ack), .i_mem_rdata(na_rdata)
  );

  // Second instance sees a zero-wait memory holding one fixed word everywhere.
  assign na_ack   = na_req;
  assign na_rdata = 32'h80FF7F01;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          nreads;
    logic [31:0] a0;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] reads[$];
  logic [31:0] ovr[logic [31:0]];
  int          exp_lat = 0;
  int          req_cyc = 0;
  int          cycle = 0;
  int          checks = 0;
  int          errors = 0;
  int          force_delay = -1;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  // Reference: gather the addressed bytes one by one, then extend.
  function automatic exp_t ref_load(input logic [31:0] a, input logic [2:0] f3, input bit allow);
    exp_t        e;
    int          size;
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    e.a0 = {a[31:2], 2'b00};
    e.data = 32'd0;
    e.err = 1'b0;
    e.nreads = 0;
    e.acc = 0;
    if (size == 0 || (!allow && (int'(a[1:0]) % size) != 0)) begin
      e.err = 1'b1;
      return e;
    end
    v = 32'd0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = byte_at(a + 32'(i));
    if (!f3[2] && size < 4 && v[8*size-1])
      for (int i = 8 * size; i < 32; i++) v[i] = 1'b1;
    e.data = v;
    e.nreads = (int'(a[1:0]) + size > 4) ? 2 : 1;
    return e;
  endfunction

  // Memory responder: random or forced wait states, stray acks while idle.
  initial begin
    int          left;
    logic        busy;
    logic [31:0] held;
    left = 0;
    busy = 1'b0;
    held = 32'd0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          held = mem_addr;
          left = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
          exp_lat += left + 1;
          chk("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
        end else begin
          chk("addr_stable", mem_addr, held);
        end
        req_cyc++;
        if (left == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mem_word(mem_addr);
          reads.push_back(mem_addr);
          busy = 1'b0;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
          left--;
        end
      end else begin
        busy = 1'b0;
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: every done pops one expectation. Latency is counted from the accept edge,
  // so a zero-wait single read gives 1 and an error gives 0.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ld_done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with data %h, expected no done", ld_data);
        end else begin
          e = sb.pop_front();
          chk("data", ld_data, e.data);
          chk("err", {31'd0, ld_err}, {31'd0, e.err});
          chk("nreads", 32'(reads.size()), 32'(e.nreads));
          if (e.nreads > 0 && reads.size() > 0) chk("rd_addr0", reads[0], e.a0);
          if (e.nreads > 1 && reads.size() > 1) chk("rd_addr1", reads[1], e.a0 + 32'd4);
          chk("latency", 32'(cycle - e.acc), 32'(exp_lat));
          chk("req_cycles", 32'(req_cyc), 32'(exp_lat));
        end
        reads.delete();
        exp_lat = 0;
        req_cyc = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [2:0] f3);
    int   n;
    exp_t e;
    n = 0;
    while (ld_ready !== 1'b1) begin
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr = $urandom;
      ld_funct3 = 3'($urandom_range(0, 7));
      @(negedge clk);
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: got ready=%b, expected 1", ld_ready);
        ld_valid = 1'b0;
        return;
      end
    end
    ld_valid = 1'b1;
    ld_addr = a;
    ld_funct3 = f3;
    e = ref_load(a, f3, 1'b1);
    e.acc = cycle + 1;
    sb.push_back(e);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic na_load(input string name, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] exp_data, input logic exp_err);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (na_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    na_valid = 1'b1;
    na_addr = a;
    na_funct3 = f3;
    @(negedge clk);
    na_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      if (na_req) seen = 1'b1;
      if (na_done) break;
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, {31'd0, na_done}, 32'd1);
    chk({name, "_data"}, na_data, exp_data);
    chk({name, "_err"}, {31'd0, na_err}, {31'd0, exp_err});
    chk({name, "_req"}, {31'd0, seen}, {31'd0, ~exp_err});
    @(negedge clk);
  endtask

  initial begin
    int          n;
    logic [31:0] a;
    ld_valid = 1'b0; ld_addr = 32'd0; ld_funct3 = 3'd0;
    na_valid = 1'b0; na_addr = 32'd0; na_funct3 = 3'd0;
    ovr[32'h100] = 32'h8899AABB;
    ovr[32'h200] = 32'h80FF7F01;
    ovr[32'h104] = 32'h44332211;
    ovr[32'h108] = 32'h88776655;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_done", {31'd0, ld_done}, 32'd0);
    chk("rst_data", ld_data, 32'd0);
    chk("rst_err", {31'd0, ld_err}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'h100, 3'd2);
    issue(32'h203, 3'd0);
    issue(32'h203, 3'd4);
    issue(32'h201, 3'd0);
    issue(32'h202, 3'd1);
    issue(32'h202, 3'd5);
    issue(32'h105, 3'd2);
    issue(32'h0FFFFFFF, 3'd1);
    issue(32'hFFFFFFFF, 3'd1);
    issue(32'hFFFFFFFE, 3'd2);
    issue(32'h100, 3'd3);
    issue(32'h100, 3'd7);
    drain();

    force_delay = 5;
    issue(32'h100, 3'd2);
    drain();
    force_delay = -1;

    repeat (250) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFC | {30'd0, a[1:0]};
      issue(a, 3'($urandom_range(0, 7)));
    end
    drain();

    // Abandon a split load while its second read is outstanding.
    force_delay = 30;
    issue(32'h105, 3'd2);
    n = 0;
    while (!(mem_req && mem_addr == 32'h108) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("reach_rd_hi", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    @(negedge clk);
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_ready", {31'd0, ld_ready}, 32'd0);
    chk("midrst_done", {31'd0, ld_done}, 32'd0);
    repeat (3) @(negedge clk);
    reads.delete();
    exp_lat = 0;
    req_cyc = 0;
    force_delay = -1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle_req", {31'd0, mem_req}, 32'd0);
    issue(32'h100, 3'd2);
    drain();

    na_load("na_lw_mis", 32'h102, 3'd2, 32'd0, 1'b1);
    na_load("na_lh_mis", 32'h201, 3'd1, 32'd0, 1'b1);
    na_load("na_illegal", 32'h200, 3'd3, 32'd0, 1'b1);
    na_load("na_lb", 32'h203, 3'd0, 32'hFFFFFF80, 1'b0);
    na_load("na_lhu", 32'h202, 3'd5, 32'h000080FF, 1'b0);
    na_load("na_lw", 32'h100, 3'd2, 32'h80FF7F01, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
